axi4l_regbank: RTL

// - Parametrised AXI4-Lite slave register bank: NREG 32-bit regs, per-reg writable/read-only select, byte strobes.
// - Independent AW/W capture; SLVERR on bad accesses; per-reg write/read strobes to user logic.
// - Sits between the PS/interconnect AXI4-Lite master port and PL control/status logic; supersedes hand-written per-IP slaves.

---
 rtl/axi4l_regbank.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/axi4l_regbank.sv
// rtl/axi4l_regbank.sv - AXI4-Lite slave register bank with byte strobes and per-reg user strobes.
// Optional IE/IS interrupt registers when AXI4L_REGBANK_INTR_EN is defined.
module axi4l_regbank #(
  parameter int                 NREG    = 4,
  parameter logic [NREG-1:0]    RO_MASK = '0,
  parameter logic [NREG*32-1:0] RST_VAL = '0,
  parameter int                 NIRQ    = 1,
  localparam int                AW      = $clog2(NREG+2)+2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [AW-1:0]      s_axi_awaddr,
  input  logic [2:0]         s_axi_awprot,
  input  logic               s_axi_awvalid,
  output logic               s_axi_awready,
  input  logic [31:0]        s_axi_wdata,
  input  logic [3:0]         s_axi_wstrb,
  input  logic               s_axi_wvalid,
  output logic               s_axi_wready,
  output logic [1:0]         s_axi_bresp,
  output logic               s_axi_bvalid,
  input  logic               s_axi_bready,
  input  logic [AW-1:0]      s_axi_araddr,
  input  logic [2:0]         s_axi_arprot,
  input  logic               s_axi_arvalid,
  output logic               s_axi_arready,
  output logic [31:0]        s_axi_rdata,
  output logic [1:0]         s_axi_rresp,
  output logic               s_axi_rvalid,
  input  logic               s_axi_rready,
  output logic [NREG*32-1:0] usr_regs,
  input  logic [NREG*32-1:0] usr_rdval,
  output logic [NREG-1:0]    usr_wr,
  output logic [NREG-1:0]    usr_rd,
  input  logic [NIRQ-1:0]    irq_evt,
  output logic               intr
);

  localparam int IW = AW-2;

  logic            rst_done;
  logic            aw_full, w_full;
  logic [IW-1:0]   aw_idx;
  logic [31:0]     w_data;
  logic [3:0]      w_strb;
  logic [31:0]     wmask;
  logic [31:0]     reg_q [NREG];
  logic            commit, ar_hs, wr_ok, rd_ok;
  logic [IW-1:0]   ar_idx;
  logic [NREG-1:0] wr_sel, rd_sel;
  logic [31:0]     rd_val;
  logic            intr_wr_hit, intr_rd_hit;
  logic [31:0]     intr_rd_val;

  assign s_axi_awready = rst_done & ~aw_full;
  assign s_axi_wready  = rst_done & ~w_full;
  assign s_axi_arready = rst_done & ~s_axi_rvalid;
  assign ar_idx        = s_axi_araddr[AW-1:2];
  assign ar_hs         = s_axi_arvalid & s_axi_arready;
  assign commit        = aw_full & w_full & (~s_axi_bvalid | s_axi_bready);
  assign wmask         = {{8{w_strb[3]}}, {8{w_strb[2]}}, {8{w_strb[1]}}, {8{w_strb[0]}}};

  always_comb begin
    wr_sel = '0;
    rd_sel = '0;
    rd_val = intr_rd_val;
    for (int i = 0; i < NREG; i++) begin
      if (aw_idx == IW'(i) && !RO_MASK[i]) wr_sel[i] = 1'b1;
      if (ar_idx == IW'(i)) begin
        rd_sel[i] = 1'b1;
        rd_val    = RO_MASK[i] ? usr_rdval[32*i +: 32] : reg_q[i];
      end
    end
    wr_ok  = (|wr_sel) | intr_wr_hit;
    rd_ok  = (|rd_sel) | intr_rd_hit;
    usr_wr = commit ? wr_sel : '0;
    usr_rd = ar_hs ? rd_sel : '0;
    for (int i = 0; i < NREG; i++) usr_regs[32*i +: 32] = reg_q[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_done <= 1'b0;
      aw_full  <= 1'b0;
      w_full   <= 1'b0;
      aw_idx   <= '0;
      w_data   <= '0;
      w_strb   <= '0;
    end else begin
      rst_done <= 1'b1;
      if (commit) begin
        aw_full <= 1'b0;
        w_full  <= 1'b0;
      end else begin
        if (s_axi_awvalid && s_axi_awready) begin
          aw_full <= 1'b1;
          aw_idx  <= s_axi_awaddr[AW-1:2];
        end
        if (s_axi_wvalid && s_axi_wready) begin
          w_full <= 1'b1;
          w_data <= s_axi_wdata;
          w_strb <= s_axi_wstrb;
        end
      end
    end
  end

  // RO slots hold zero forever since their usr_wr bit can never assert
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) reg_q[i] <= RO_MASK[i] ? 32'h0 : RST_VAL[32*i +: 32];
    end else begin
      for (int i = 0; i < NREG; i++)
        if (usr_wr[i]) reg_q[i] <= (reg_q[i] & ~wmask) | (w_data & wmask);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_axi_bvalid <= 1'b0;
      s_axi_bresp  <= 2'b00;
    end else if (commit) begin
      s_axi_bvalid <= 1'b1;
      s_axi_bresp  <= wr_ok ? 2'b00 : 2'b10;
    end else if (s_axi_bready) begin
      s_axi_bvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_axi_rvalid <= 1'b0;
      s_axi_rdata  <= '0;
      s_axi_rresp  <= 2'b00;
    end else if (ar_hs) begin
      s_axi_rvalid <= 1'b1;
      s_axi_rdata  <= rd_ok ? rd_val : 32'h0;
      s_axi_rresp  <= rd_ok ? 2'b00 : 2'b10;
    end else if (s_axi_rready) begin
      s_axi_rvalid <= 1'b0;
    end
  end

`ifdef AXI4L_REGBANK_INTR_EN
  localparam logic [IW-1:0] IE_IDX = IW'(NREG);
  localparam logic [IW-1:0] IS_IDX = IW'(NREG+1);

  logic [NIRQ-1:0] ie_q, is_q, clr;

  assign intr_wr_hit = (aw_idx == IE_IDX) || (aw_idx == IS_IDX);
  assign intr_rd_hit = (ar_idx == IE_IDX) || (ar_idx == IS_IDX);
  assign intr_rd_val = (ar_idx == IE_IDX) ? 32'(ie_q) : (ar_idx == IS_IDX) ? 32'(is_q) : 32'h0;
  assign clr         = (commit && aw_idx == IS_IDX) ? (w_data[NIRQ-1:0] & wmask[NIRQ-1:0]) : '0;

  // New events take priority over a W1C clear landing in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ie_q <= '0;
      is_q <= '0;
      intr <= 1'b0;
    end else begin
      if (commit && aw_idx == IE_IDX)
        ie_q <= (ie_q & ~wmask[NIRQ-1:0]) | (w_data[NIRQ-1:0] & wmask[NIRQ-1:0]);
      is_q <= (is_q & ~clr) | irq_evt;
      intr <= |(ie_q & is_q);
    end
  end
`else
  logic unused_irq;
  assign unused_irq  = ^irq_evt;
  assign intr_wr_hit = 1'b0;
  assign intr_rd_hit = 1'b0;
  assign intr_rd_val = 32'h0;
  assign intr        = 1'b0;
`endif

  logic unused_ok;
  assign unused_ok = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0], usr_rdval};

endmodule
